// File: rtl/axi_sram_slave_pkg.sv
// -----------------------------------------------------------------------------
// axi_sram_slave_pkg
// Shared types and constants for the AXI-to-SRAM system memory slave.
//   - AXI_DATA_WIDTH : bus/SRAM data width macro (defaults to 32 when the
//                      surrounding build does not provide it)
//   - axi_sram_state_t : controller state encoding
//   - AXI_RESP_OKAY    : the only write response this slave ever returns
//   - SKID_ENTRIES     : depth of the read-path skid buffer
// -----------------------------------------------------------------------------
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

package axi_sram_slave_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_DATA = 2'd1,
    WRITE_RESP = 2'd2,
    READ_DATA  = 2'd3
  } axi_sram_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Two entries are enough to cover the one-cycle SRAM latency while the
  // master stalls rready, without ever dropping an in-flight word.
  localparam int SKID_ENTRIES = 2;

endpackage

// File: rtl/axi_sram_slave_if.sv
// -----------------------------------------------------------------------------
// axi_sram_slave_if
// Reduced AXI bus between the L2 AXI master and the SRAM slave.
//   AW : awaddr[31:0], awlen[7:0], awvalid, awready
//   W  : wdata, wlast, wvalid, wready
//   B  : bvalid, bready, bresp[1:0]
//   AR : araddr[31:0], arlen[7:0], arvalid, arready
//   R  : rdata, rvalid, rready
// Modports: master (drives addresses/write data), slave (drives readies,
// responses and read data).
// -----------------------------------------------------------------------------
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

interface axi_sram_slave_if;

  logic [31:0]                 awaddr;
  logic [7:0]                  awlen;
  logic                        awvalid;
  logic                        awready;

  logic [`AXI_DATA_WIDTH-1:0]  wdata;
  logic                        wlast;
  logic                        wvalid;
  logic                        wready;

  logic                        bvalid;
  logic                        bready;
  logic [1:0]                  bresp;

  logic [31:0]                 araddr;
  logic [7:0]                  arlen;
  logic                        arvalid;
  logic                        arready;

  logic [`AXI_DATA_WIDTH-1:0]  rdata;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output awaddr, awlen, awvalid,
    input  awready,
    output wdata, wlast, wvalid,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output araddr, arlen, arvalid,
    input  arready,
    input  rdata, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awvalid,
    output awready,
    input  wdata, wlast, wvalid,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  araddr, arlen, arvalid,
    output arready,
    output rdata, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_sram_slave_fifo.sv
// -----------------------------------------------------------------------------
// axi_sram_slave_fifo
// Small synchronous first-word-fall-through FIFO used as the read skid buffer.
// Parameters: WIDTH (entry width), NUM_ENTRIES (depth).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_data   write side; a push while full is accepted only together
//                     with a pop in the same cycle
//   pop, pop_data     read side; pop_data is the head entry whenever !empty
//   empty, full       occupancy flags
//   almost_full       at most one free entry left
// -----------------------------------------------------------------------------
module axi_sram_slave_fifo #(
  parameter int WIDTH       = 32,
  parameter int NUM_ENTRIES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic             almost_full
);

  localparam int PTR_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

  logic [WIDTH-1:0] mem [NUM_ENTRIES];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_ENTRIES - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count/pointers alone decide
  // what is valid, and leaving the array reset-free lets it map to LUT RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data    = mem[rd_ptr];
  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(NUM_ENTRIES));
  assign almost_full = (count >= CNT_W'(NUM_ENTRIES - 1));

endmodule

// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
// AXI slave serving L2 line-fill reads and writeback bursts from a single-port
// synchronous SRAM (1-cycle read latency). One burst in flight at a time;
// writes win over reads when both address channels are valid, and a pending
// read waits until the write response has been accepted.
//
// Parameters:
//   MEM_WORDS   SRAM depth in data words (power of two)
// Ports:
//   clk          clock
//   reset        synchronous, active-high; abandons any burst in progress
//   axi_bus      axi_sram_slave_if.slave (AW/W/B/AR/R channels)
//   sram_addr    SRAM word address
//   sram_rd_en   SRAM read strobe, data returns on sram_rdata next cycle
//   sram_wr_en   SRAM write strobe
//   sram_wdata   SRAM write data
//   sram_rdata   SRAM read data
//   proto_err    (AXI_SRAM_PROTO_CHECK_EN only) sticky protocol-error flag
//
// Build option: define AXI_SRAM_PROTO_CHECK_EN to add the protocol checker
// (wlast mismatched to the beat count, or wvalid outside the write data
// phase) and its proto_err output.
// -----------------------------------------------------------------------------
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int MEM_WORDS = 65536
) (
  input  logic                           clk,
  input  logic                           reset,
  axi_sram_slave_if.slave                axi_bus,
  output logic [$clog2(MEM_WORDS)-1:0]   sram_addr,
  output logic                           sram_rd_en,
  output logic                           sram_wr_en,
  output logic [`AXI_DATA_WIDTH-1:0]     sram_wdata,
  input  logic [`AXI_DATA_WIDTH-1:0]     sram_rdata
`ifdef AXI_SRAM_PROTO_CHECK_EN
  ,
  output logic                           proto_err
`endif
);

  localparam int ADDR_WIDTH = $clog2(MEM_WORDS);

  axi_sram_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;    // next SRAM word to touch
  logic [7:0]               beats_q, beats_d;  // bus beats left, minus one
  logic [7:0]               issue_q, issue_d;  // SRAM reads still to issue
  logic                     rd_pending_q;      // SRAM word arrives this cycle

  logic                     awready, arready, wready, bvalid, rvalid;
  logic                     fifo_pop;
  logic                     fifo_empty, fifo_full, fifo_almost_full;
  logic [`AXI_DATA_WIDTH-1:0] fifo_head;
  logic                     rd_room;

  // A new SRAM read may only be launched if, counting the word already in
  // flight, the skid buffer cannot overflow when the master stalls. A pop in
  // the same cycle always frees the slot the new word will need.
  assign rd_room = fifo_pop ||
                   (!fifo_full && !(fifo_almost_full && rd_pending_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      beats_q      <= '0;
      issue_q      <= '0;
      rd_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beats_q      <= beats_d;
      issue_q      <= issue_d;
      rd_pending_q <= sram_rd_en;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    beats_d    = beats_q;
    issue_d    = issue_q;
    awready    = 1'b0;
    arready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    rvalid     = 1'b0;
    fifo_pop   = 1'b0;
    sram_addr  = addr_q;
    sram_rd_en = 1'b0;
    sram_wr_en = 1'b0;
    sram_wdata = '0;

    case (state_q)
      IDLE: begin
        if (axi_bus.awvalid) begin
          // Write first: keeps the master's writeback ahead of its refill.
          awready = 1'b1;
          addr_d  = axi_bus.awaddr[ADDR_WIDTH+1:2];
          beats_d = axi_bus.awlen;
          state_d = WRITE_DATA;
        end else if (axi_bus.arvalid) begin
          // First SRAM read goes out in the arready cycle itself so the
          // first beat is on the bus two cycles later.
          arready    = 1'b1;
          sram_rd_en = 1'b1;
          sram_addr  = axi_bus.araddr[ADDR_WIDTH+1:2];
          addr_d     = axi_bus.araddr[ADDR_WIDTH+1:2] + 1'b1;
          beats_d    = axi_bus.arlen;
          issue_d    = axi_bus.arlen;
          state_d    = READ_DATA;
        end
      end

      WRITE_DATA: begin
        wready = 1'b1;
        if (axi_bus.wvalid) begin
          // Framing comes from the beat count; wlast is not trusted.
          sram_wr_en = 1'b1;
          sram_wdata = axi_bus.wdata;
          addr_d     = addr_q + 1'b1;
          if (beats_q == 8'd0) state_d = WRITE_RESP;
          else                 beats_d = beats_q - 1'b1;
        end
      end

      WRITE_RESP: begin
        bvalid = 1'b1;
        if (axi_bus.bready) state_d = IDLE;
      end

      READ_DATA: begin
        rvalid   = !fifo_empty;
        fifo_pop = rvalid && axi_bus.rready;
        if (fifo_pop) begin
          if (beats_q == 8'd0) state_d = IDLE;
          else                 beats_d = beats_q - 1'b1;
        end
        if ((issue_q != 8'd0) && rd_room) begin
          sram_rd_en = 1'b1;
          addr_d     = addr_q + 1'b1;
          issue_d    = issue_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs are held quiet for the whole reset cycle, including any
    // combinational response to valids the master is still driving.
    if (reset) begin
      awready    = 1'b0;
      arready    = 1'b0;
      wready     = 1'b0;
      bvalid     = 1'b0;
      rvalid     = 1'b0;
      fifo_pop   = 1'b0;
      sram_addr  = '0;
      sram_rd_en = 1'b0;
      sram_wr_en = 1'b0;
      sram_wdata = '0;
    end
  end

  axi_sram_slave_fifo #(
    .WIDTH       (`AXI_DATA_WIDTH),
    .NUM_ENTRIES (SKID_ENTRIES)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .push        (rd_pending_q),
    .push_data   (sram_rdata),
    .pop         (fifo_pop),
    .pop_data    (fifo_head),
    .empty       (fifo_empty),
    .full        (fifo_full),
    .almost_full (fifo_almost_full)
  );

  assign axi_bus.awready = awready;
  assign axi_bus.arready = arready;
  assign axi_bus.wready  = wready;
  assign axi_bus.bvalid  = bvalid;
  assign axi_bus.bresp   = AXI_RESP_OKAY;
  assign axi_bus.rvalid  = rvalid;
  assign axi_bus.rdata   = rvalid ? fifo_head : '0;

`ifdef AXI_SRAM_PROTO_CHECK_EN
  logic proto_err_q;
  logic proto_viol;

  always_comb begin
    proto_viol = 1'b0;
    if (axi_bus.wvalid) begin
      if (state_q != WRITE_DATA)                       proto_viol = 1'b1;
      else if (axi_bus.wlast != (beats_q == 8'd0))     proto_viol = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)           proto_err_q <= 1'b0;
    else if (proto_viol) proto_err_q <= 1'b1;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && proto_viol && !proto_err_q)
      $error("axi_sram_slave: protocol error (state=%s wlast=%b beats_left=%0d)",
             state_q.name(), axi_bus.wlast, beats_q);
  end
`endif

  assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_axi_sram_slave.sv
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module tb_axi_sram_slave;

  localparam int MEM_WORDS = 1024;
  localparam int AW        = $clog2(MEM_WORDS);
  localparam int DW        = `AXI_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] sram_addr;
  logic          sram_rd_en;
  logic          sram_wr_en;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
`ifdef AXI_SRAM_PROTO_CHECK_EN
  logic          proto_err;
`endif

  axi_sram_slave_if axi_bus ();

  axi_sram_slave #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .axi_bus    (axi_bus),
    .sram_addr  (sram_addr),
    .sram_rd_en (sram_rd_en),
    .sram_wr_en (sram_wr_en),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
`ifdef AXI_SRAM_PROTO_CHECK_EN
    ,
    .proto_err  (proto_err)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference memory: what the system memory must contain after every
  // completed write beat, indexed by word address modulo the depth.
  logic [DW-1:0] ref_mem  [MEM_WORDS];
  // The physical SRAM the slave drives.
  logic [DW-1:0] sram_mem [MEM_WORDS];
  logic [AW-1:0] rd_log [$];

  always @(posedge clk) begin
    if (sram_wr_en === 1'b1) sram_mem[sram_addr] <= sram_wdata;
    if (sram_rd_en === 1'b1) begin
      sram_rdata <= sram_mem[sram_addr];
      rd_log.push_back(sram_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_phase(input logic [31:0] addr, input logic [7:0] len);
    int guard = 0;
    axi_bus.awaddr  = addr;
    axi_bus.awlen   = len;
    axi_bus.awvalid = 1'b1;
    @(negedge clk);
    while (axi_bus.awready !== 1'b1 && guard < 20) begin
      tick();
      @(negedge clk);
      guard++;
    end
    checks++;
    if (axi_bus.awready !== 1'b1) begin
      failures++;
      $display("FAIL aw_handshake: awready=%b, required 1 within 20 cycles", axi_bus.awready);
    end
    tick();
    axi_bus.awvalid = 1'b0;
  endtask

  task automatic w_phase(input int unsigned word, input int len, input bit seq, input bit gaps);
    int            beat  = 0;
    int            guard = 0;
    int unsigned   exp_word;
    logic [DW-1:0] d;
    d = seq ? DW'(0) : DW'($urandom);
    while (beat <= len && guard < 1000) begin
      exp_word       = (word + beat) % MEM_WORDS;
      axi_bus.wvalid = !gaps || ($urandom_range(0, 2) != 0);
      axi_bus.wdata  = d;
      axi_bus.wlast  = (beat == len);
      @(negedge clk);
      checks++;
      if (axi_bus.wvalid) begin
        if (axi_bus.wready !== 1'b1 || sram_wr_en !== 1'b1 ||
            sram_addr !== AW'(exp_word) || sram_wdata !== d) begin
          failures++;
          $display("FAIL write_beat: beat=%0d wready=%b wr_en=%b addr=%h data=%h, required 1 1 %h %h",
                   beat, axi_bus.wready, sram_wr_en, sram_addr, sram_wdata, AW'(exp_word), d);
        end
        ref_mem[exp_word] = d;
        beat++;
        d = seq ? DW'(beat) : DW'($urandom);
      end else if (axi_bus.wready !== 1'b1 || sram_wr_en !== 1'b0) begin
        failures++;
        $display("FAIL write_gap: wready=%b wr_en=%b, required 1 0", axi_bus.wready, sram_wr_en);
      end
      checks++;
      if (axi_bus.arready !== 1'b0) begin
        failures++;
        $display("FAIL write_ar_blocked: arready=%b, required 0", axi_bus.arready);
      end
      tick();
      guard++;
    end
    axi_bus.wvalid = 1'b0;
    axi_bus.wlast  = 1'b0;
    checks++;
    if (beat != len + 1) begin
      failures++;
      $display("FAIL write_count: beats=%0d, required %0d", beat, len + 1);
    end
  endtask

  task automatic b_phase(input int hold);
    axi_bus.bready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (axi_bus.bvalid !== 1'b1 || sram_wr_en !== 1'b0 || axi_bus.arready !== 1'b0) begin
        failures++;
        $display("FAIL bresp_hold: bvalid=%b wr_en=%b arready=%b, required 1 0 0",
                 axi_bus.bvalid, sram_wr_en, axi_bus.arready);
      end
      tick();
    end
    axi_bus.bready = 1'b1;
    @(negedge clk);
    checks++;
    if (axi_bus.bvalid !== 1'b1 || axi_bus.bresp !== 2'b00) begin
      failures++;
      $display("FAIL bresp_accept: bvalid=%b bresp=%b, required 1 00", axi_bus.bvalid, axi_bus.bresp);
    end
    tick();
    axi_bus.bready = 1'b0;
    #1;
    checks++;
    if (axi_bus.bvalid !== 1'b0) begin
      failures++;
      $display("FAIL bresp_done: bvalid=%b, required 0", axi_bus.bvalid);
    end
  endtask

  task automatic ar_phase(input logic [31:0] addr, input logic [7:0] len);
    int guard = 0;
    axi_bus.araddr  = addr;
    axi_bus.arlen   = len;
    axi_bus.arvalid = 1'b1;
    @(negedge clk);
    while (axi_bus.arready !== 1'b1 && guard < 20) begin
      tick();
      @(negedge clk);
      guard++;
    end
    checks++;
    if (axi_bus.arready !== 1'b1) begin
      failures++;
      $display("FAIL ar_handshake: arready=%b, required 1 within 20 cycles", axi_bus.arready);
    end
    tick();
    axi_bus.arvalid = 1'b0;
  endtask

  // mode 0: rready held high; 1: rready pattern 1,0,0,1; 2: random rready.
  task automatic r_phase(input int unsigned word, input int len, input int mode);
    int            beat  = 0;
    int            cyc   = 1;
    int            first = -1;
    int            last  = -1;
    logic [DW-1:0] exp;
    while (beat <= len && cyc < 2000) begin
      case (mode)
        0:       axi_bus.rready = 1'b1;
        1:       axi_bus.rready = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
        default: axi_bus.rready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (axi_bus.rvalid === 1'b1 && first < 0) first = cyc;
      if (axi_bus.rvalid === 1'b1 && axi_bus.rready) begin
        exp = ref_mem[(word + beat) % MEM_WORDS];
        checks++;
        if (axi_bus.rdata !== exp) begin
          failures++;
          $display("FAIL read_beat: beat=%0d rdata=%h, required %h", beat, axi_bus.rdata, exp);
        end
        beat++;
        last = cyc;
      end
      tick();
      cyc++;
    end
    axi_bus.rready = 1'b0;
    checks++;
    if (beat != len + 1) begin
      failures++;
      $display("FAIL read_count: beats=%0d, required %0d", beat, len + 1);
    end
    checks++;
    if (first != 2) begin
      failures++;
      $display("FAIL read_latency: first rvalid at cycle %0d after arready, required 2", first);
    end
    if (mode == 0) begin
      checks++;
      if (last - first != len) begin
        failures++;
        $display("FAIL read_throughput: %0d cycles first-to-last, required %0d", last - first, len);
      end
    end
    @(negedge clk);
    checks++;
    if (axi_bus.rvalid !== 1'b0 || sram_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL read_done: rvalid=%b rd_en=%b, required 0 0", axi_bus.rvalid, sram_rd_en);
    end
    tick();
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    axi_bus.awvalid = 1'b1;
    axi_bus.arvalid = 1'b1;
    axi_bus.wvalid  = 1'b1;
    axi_bus.rready  = 1'b1;
    axi_bus.bready  = 1'b1;
    axi_bus.awaddr  = $urandom;
    axi_bus.araddr  = $urandom;
    axi_bus.awlen   = 8'd3;
    axi_bus.arlen   = 8'd3;
    axi_bus.wdata   = DW'($urandom);
    axi_bus.wlast   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({axi_bus.awready, axi_bus.arready, axi_bus.wready, axi_bus.bvalid, axi_bus.rvalid,
           sram_rd_en, sram_wr_en} !== 7'b0 || axi_bus.rdata !== '0 ||
          sram_addr !== '0 || sram_wdata !== '0) begin
        failures++;
        $display("FAIL reset_outputs: aw/ar/w/b/r/rd/wr=%b%b%b%b%b%b%b rdata=%h addr=%h wdata=%h, required all 0",
                 axi_bus.awready, axi_bus.arready, axi_bus.wready, axi_bus.bvalid, axi_bus.rvalid,
                 sram_rd_en, sram_wr_en, axi_bus.rdata, sram_addr, sram_wdata);
      end
      tick();
    end
    axi_bus.awvalid = 1'b0;
    axi_bus.arvalid = 1'b0;
    axi_bus.wvalid  = 1'b0;
    axi_bus.rready  = 1'b0;
    axi_bus.bready  = 1'b0;
    reset           = 1'b0;
    @(negedge clk);
    checks++;
    if ({axi_bus.awready, axi_bus.arready, axi_bus.wready, axi_bus.bvalid, axi_bus.rvalid,
         sram_rd_en, sram_wr_en} !== 7'b0) begin
      failures++;
      $display("FAIL reset_idle: aw/ar/w/b/r/rd/wr=%b%b%b%b%b%b%b, required all 0",
               axi_bus.awready, axi_bus.arready, axi_bus.wready, axi_bus.bvalid, axi_bus.rvalid,
               sram_rd_en, sram_wr_en);
    end
    tick();
  endtask

  task automatic test_write_burst();
    aw_phase(32'h100, 8'd15);
    w_phase(32'h40, 15, 1'b1, 1'b0);
    b_phase(3);
  endtask

  task automatic test_read_burst();
    ar_phase(32'h100, 8'd15);
    r_phase(32'h40, 15, 0);
  endtask

  task automatic test_read_backpressure();
    ar_phase(32'h100, 8'd15);
    r_phase(32'h40, 15, 1);
  endtask

  task automatic test_arbitration();
    axi_bus.awaddr  = 32'h200;
    axi_bus.awlen   = 8'd3;
    axi_bus.araddr  = 32'h100;
    axi_bus.arlen   = 8'd15;
    axi_bus.awvalid = 1'b1;
    axi_bus.arvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (axi_bus.awready !== 1'b1 || axi_bus.arready !== 1'b0) begin
      failures++;
      $display("FAIL arb_write_first: awready=%b arready=%b, required 1 0", axi_bus.awready, axi_bus.arready);
    end
    tick();
    axi_bus.awvalid = 1'b0;
    w_phase(32'h80, 3, 1'b0, 1'b1);
    b_phase(2);
    checks++;
    if (axi_bus.arready !== 1'b1) begin
      failures++;
      $display("FAIL arb_read_after_resp: arready=%b, required 1", axi_bus.arready);
    end
    ar_phase(32'h100, 8'd15);
    r_phase(32'h40, 15, 2);
  endtask

  task automatic test_wrap();
    int unsigned   base = MEM_WORDS - 2;
    logic [AW-1:0] exp_addr;
    aw_phase(32'(base * 4), 8'd3);
    w_phase(base, 3, 1'b0, 1'b0);
    b_phase(0);
    rd_log.delete();
    ar_phase(32'(base * 4), 8'd3);
    r_phase(base, 3, 0);
    checks++;
    if (rd_log.size() != 4) begin
      failures++;
      $display("FAIL wrap_read_count: %0d SRAM reads, required 4", rd_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_addr = AW'((base + i) % MEM_WORDS);
        checks++;
        if (rd_log[i] !== exp_addr) begin
          failures++;
          $display("FAIL wrap_read_addr: read %0d addr=%h, required %h", i, rd_log[i], exp_addr);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] addr = {20'h0, 10'($urandom_range(0, MEM_WORDS - 1)), 2'b00};
    int unsigned word = (addr >> 2) % MEM_WORDS;
    int          beat = 0;
    int          cyc  = 0;
    aw_phase(addr, 8'd15);
    w_phase(word, 15, 1'b0, 1'b0);
    b_phase(1);
    ar_phase(addr, 8'd15);
    axi_bus.rready = 1'b1;
    while (beat < 5 && cyc < 100) begin
      @(negedge clk);
      if (axi_bus.rvalid === 1'b1) beat++;
      tick();
      cyc++;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (axi_bus.rvalid !== 1'b0 || axi_bus.arready !== 1'b0 || sram_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_read: rvalid=%b arready=%b rd_en=%b, required 0 0 0",
               axi_bus.rvalid, axi_bus.arready, sram_rd_en);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (axi_bus.rvalid !== 1'b0 || sram_rd_en !== 1'b0) begin
        failures++;
        $display("FAIL reset_quiet: rvalid=%b rd_en=%b, required 0 0", axi_bus.rvalid, sram_rd_en);
      end
      tick();
    end
    axi_bus.rready = 1'b0;
    ar_phase(addr, 8'd15);
    r_phase(word, 15, 0);
  endtask

  task automatic test_random();
    logic [31:0] mask = 32'(MEM_WORDS * 4 - 1);
    logic [31:0] waddr;
    logic [31:0] raddr;
    int          len;
    int unsigned word;
    for (int it = 0; it < 10; it++) begin
      waddr = $urandom;
      len   = $urandom_range(0, 20);
      word  = (waddr >> 2) % MEM_WORDS;
      aw_phase(waddr, 8'(len));
      w_phase(word, len, 1'b0, 1'($urandom_range(0, 1)));
      b_phase($urandom_range(0, 3));
      // Same word range, different upper (aliased) bits and byte offset.
      raddr = ($urandom & ~mask) | (waddr & mask & ~32'h3) | 32'($urandom_range(0, 3));
      ar_phase(raddr, 8'(len));
      r_phase(word, len, 2);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      ref_mem[i]  = '0;
      sram_mem[i] = '0;
    end
    axi_bus.awvalid = 1'b0;
    axi_bus.arvalid = 1'b0;
    axi_bus.wvalid  = 1'b0;
    axi_bus.wlast   = 1'b0;
    axi_bus.bready  = 1'b0;
    axi_bus.rready  = 1'b0;

    test_reset();
    test_write_burst();
    test_read_burst();
    test_read_backpressure();
    test_arbitration();
    test_wrap();
    test_reset_mid_read();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
